instr_aligner: RTL and testbench
================================

// Module: instr_aligner
// PURPOSE
// - Fetch-to-decode alignment stage. Accepts 32-bit fetch words and emits one aligned RVI or RVC instruction per cycle.
// - Carries a 16-bit leftover buffer so 32-bit instructions that straddle two words are reassembled.
// - Forwards fetch error, prediction and align-error flags to the decoder.
// - Sits between the fetch/predictor stage and the decoder.
// PARAMETERS
// - none (XLEN fixed at 32; fetch-error encoding taken from p_hardisc: FETCH_VALID = no error)
// PORTS
// - s_clk_i            in   1   clock
// - s_resetn_i         in   1   reset, synchronous, active-low
// - s_flush_i          in   1   pipeline redirect: drop all buffered state this cycle
// - s_fetch_valid_i    in   1   fetch word valid
// - s_fetch_ready_o    out  1   aligner accepts the word this cycle
// - s_fetch_data_i     in   32  fetch word (halfword0 = [15:0], halfword1 = [31:16])
// - s_fetch_error_i    in   3   fetch error code of the word
// - s_fetch_pred_i     in   1   predictor redirected after this word; its halfword1 ends the stream
// - s_fetch_hw_i       in   1   word fetched for a halfword-aligned target: halfword0 is invalid
// - s_valid_o          out  1   aligned instruction valid
// - s_ready_i          in   1   decoder accepts the instruction
// - s_instr_o          out  32  aligned instruction; RVC is zero-extended {16'b0,hw}
// - s_fetch_error_o    out  3   fetch error attached to the instruction
// - s_align_error_o    out  1   instruction cannot be completed (goes to decoder align-error input)
// - s_prediction_o     out  1   instruction carries the predictor decision
// BEHAVIOUR
// - Storage
//   - W: word register holding data, err, pred, hw and the W.valid flag.
//   - W.hw is set on load when s_fetch_hw_i=1 and marks halfword0 as invalid/skipped.
//   - L: leftover halfword holding hw, err and the L.valid flag.
// - Reset: on s_resetn_i=0 at the clock edge, W.valid=0 and L.valid=0.
//   - All outputs read 0. s_fetch_error_o = FETCH_VALID. s_fetch_ready_o = 1.
// - Latency: a word accepted in cycle N can drive s_valid_o in cycle N+1. No combinational path from fetch inputs to outputs.
// - Input handshake
//   - Transfer happens when s_fetch_valid_i & s_fetch_ready_o.
//   - s_fetch_ready_o = ~W.valid | (W fully consumed this cycle).
// - Output handshake
//   - Transfer happens when s_valid_o & s_ready_i.
//   - While s_ready_i=0 all outputs are held stable and no state changes (except on flush).
// - Selection, priority top-down. rvc(h) = h[1:0] != 2'b11.
//   1. L.valid & rvc(L.hw): emit {16'b0,L.hw}. Clear L. W is untouched.
//   2. L.valid & ~rvc(L.hw) & W.valid:
//      - Emit {W[15:0],L.hw}.
//      - Error = L.err if it is not FETCH_VALID, otherwise W.err.
//      - W[31:16] moves into L, unless W.pred=1 (see prediction rule).
//      - W is consumed.
//   3. L.valid & ~rvc(L.hw) & ~W.valid: s_valid_o=0 (wait for the next word).
//   4. ~L.valid, W.valid & W.err != FETCH_VALID: emit W as a whole with that error. Consume W. L stays empty.
//   5. ~L.valid, W.valid & W.hw: treat W[31:16] as the start (same handling as an upper half).
//   6. ~L.valid, W.valid, start at halfword0:
//      - rvc(W[15:0]): emit it; W[31:16] moves into L.
//      - otherwise: emit the full W.
// - Upper-half rule (halfword1 is the start of an instruction)
//   - If rvc: emitted in a later cycle from L.
//   - If it is a 32-bit start and W.pred=0: kept in L.
//   - If it is a 32-bit start and W.pred=1:
//     - Emit {16'b0,hw} with s_align_error_o=1 and s_prediction_o=1.
//     - L is not loaded.
// - Prediction
//   - s_prediction_o = W.pred only for the instruction containing W's halfword1; otherwise 0.
//   - After a W.pred word, L is always empty.
// - s_fetch_hw_i arriving while L.valid=1: L is discarded (redirect boundary) before W is processed.
// - Flush: s_flush_i=1 clears W.valid and L.valid at the edge and forces s_valid_o=0 in that cycle.
//   - A fetch word offered in the same cycle is dropped.
//   - s_flush_i has priority over every handshake.
// - Reset or flush in the middle of a split instruction discards the partial halfword. No instruction is emitted.
// TESTING
// - T1 aligned RVI: word 0x00A50513, hw=0, pred=0
//   -> next cycle s_instr_o=0x00A50513, valid=1, align_err=0, pred=0.
// - T2 two RVC: word 0x45014505
//   -> 0x00004505, then 0x00004501.
//   -> s_fetch_ready_o=1 during the second output.
// - T3 split: words 0x05134505 then 0x450100A5
//   -> outputs 0x00004505, 0x00A50513, 0x00004501.
// - T4 predicted dangling: word 0x05134505 with pred=1
//   -> 0x00004505 (pred=0), then 0x00000513 with align_err=1, pred=1.
//   -> L is empty afterwards.
// - T5 flush mid split: after 0x05134505, assert flush with the second word offered
//   -> no output; the next word 0x00A50513 is emitted alone.
// - T6 stall and error: s_ready_i=0 for 3 cycles
//   -> outputs stable and s_fetch_ready_o=0 once W is full.
//   -> a word with error 3'b010 is emitted whole, error=3'b010.

Source files
------------

// File: rtl/instr_aligner.sv
// Fetch-to-decode alignment stage: turns 32-bit fetch words into one RVI or RVC
// instruction per cycle, reassembling 32-bit instructions split across two words.
`timescale 1ns/1ps

module instr_aligner (
    input  logic        s_clk_i,
    input  logic        s_resetn_i,
    input  logic        s_flush_i,
    input  logic        s_fetch_valid_i,
    output logic        s_fetch_ready_o,
    input  logic [31:0] s_fetch_data_i,
    input  logic [2:0]  s_fetch_error_i,
    input  logic        s_fetch_pred_i,
    input  logic        s_fetch_hw_i,
    output logic        s_valid_o,
    input  logic        s_ready_i,
    output logic [31:0] s_instr_o,
    output logic [2:0]  s_fetch_error_o,
    output logic        s_align_error_o,
    output logic        s_prediction_o
);

    localparam logic [2:0] FETCH_VALID = 3'b000;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_L_RVC,
        SEL_SPLIT,
        SEL_WAIT,
        SEL_W_ERR,
        SEL_W_UPPER,
        SEL_W_LOWER
    } sel_t;

    // Word register W
    logic [31:0] w_data;
    logic [2:0]  w_err;
    logic        w_pred;
    logic        w_hw;
    logic        w_valid;

    // Leftover halfword L
    logic [15:0] l_hw;
    logic [2:0]  l_err;
    logic        l_valid;

    sel_t        sel;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [2:0]  out_err;
    logic        out_align;
    logic        out_pred;
    logic        w_take;
    logic        w_half;
    logic        l_clear;
    logic        l_load;
    logic [15:0] l_load_hw;
    logic [2:0]  l_load_err;
    logic        move;
    logic        advance;
    logic        load;

    function automatic logic is_rvc(input logic [15:0] h);
        return h[1:0] != 2'b11;
    endfunction

    // Everything below depends only on registered state (plus the decoder's
    // ready for the commit decision), so fetch inputs never reach the outputs.
    // A predicted word never parks its halfword1 in L: W is kept with hw set
    // so the instruction starting there can still carry the prediction.
    always_comb begin
        sel        = SEL_NONE;
        out_valid  = 1'b0;
        out_instr  = 32'h0;
        out_err    = FETCH_VALID;
        out_align  = 1'b0;
        out_pred   = 1'b0;
        w_take     = 1'b0;
        w_half     = 1'b0;
        l_clear    = 1'b0;
        l_load     = 1'b0;
        l_load_hw  = w_data[31:16];
        l_load_err = w_err;
        move       = 1'b0;

        if (l_valid && is_rvc(l_hw)) begin
            sel       = SEL_L_RVC;
            out_valid = 1'b1;
            out_instr = {16'h0, l_hw};
            out_err   = l_err;
            l_clear   = 1'b1;
        end else if (l_valid && w_valid) begin
            sel       = SEL_SPLIT;
            out_valid = 1'b1;
            out_instr = {w_data[15:0], l_hw};
            out_err   = (l_err != FETCH_VALID) ? l_err : w_err;
            l_clear   = 1'b1;
            if (w_pred) begin
                w_half = 1'b1;
            end else begin
                w_take = 1'b1;
                l_load = 1'b1;
            end
        end else if (l_valid) begin
            sel = SEL_WAIT;
        end else if (w_valid && w_err != FETCH_VALID) begin
            sel       = SEL_W_ERR;
            out_valid = 1'b1;
            out_instr = w_data;
            out_err   = w_err;
            out_pred  = w_pred;
            w_take    = 1'b1;
        end else if (w_valid && w_hw) begin
            sel = SEL_W_UPPER;
            if (is_rvc(w_data[31:16])) begin
                out_valid = 1'b1;
                out_instr = {16'h0, w_data[31:16]};
                out_err   = w_err;
                out_pred  = w_pred;
                w_take    = 1'b1;
            end else if (w_pred) begin
                out_valid = 1'b1;
                out_instr = {16'h0, w_data[31:16]};
                out_err   = w_err;
                out_align = 1'b1;
                out_pred  = 1'b1;
                w_take    = 1'b1;
            end else begin
                move   = 1'b1;
                w_take = 1'b1;
                l_load = 1'b1;
            end
        end else if (w_valid) begin
            sel       = SEL_W_LOWER;
            out_valid = 1'b1;
            out_err   = w_err;
            if (is_rvc(w_data[15:0])) begin
                out_instr = {16'h0, w_data[15:0]};
                if (w_pred) begin
                    w_half = 1'b1;
                end else begin
                    w_take = 1'b1;
                    l_load = 1'b1;
                end
            end else begin
                out_instr = w_data;
                out_pred  = w_pred;
                w_take    = 1'b1;
            end
        end
    end

    assign advance         = (out_valid & s_ready_i) | move;
    assign s_fetch_ready_o = ~w_valid | (advance & w_take);
    assign load            = s_fetch_valid_i & s_fetch_ready_o & ~s_flush_i;

    assign s_valid_o       = out_valid & ~s_flush_i;
    assign s_instr_o       = out_instr;
    assign s_fetch_error_o = out_err;
    assign s_align_error_o = out_align;
    assign s_prediction_o  = out_pred;

    always_ff @(posedge s_clk_i) begin
        if (!s_resetn_i) begin
            w_valid <= 1'b0;
            l_valid <= 1'b0;
        end else if (s_flush_i) begin
            w_valid <= 1'b0;
            l_valid <= 1'b0;
        end else begin
            if (advance) begin
                if (l_clear) l_valid <= 1'b0;
                if (l_load) begin
                    l_valid <= 1'b1;
                    l_hw    <= l_load_hw;
                    l_err   <= l_load_err;
                end
                if (w_half) w_hw <= 1'b1;
                if (w_take) w_valid <= 1'b0;
            end
            if (load) begin
                w_valid <= 1'b1;
                w_data  <= s_fetch_data_i;
                w_err   <= s_fetch_error_i;
                w_pred  <= s_fetch_pred_i;
                w_hw    <= s_fetch_hw_i;
                // A halfword-aligned target is a redirect: stale leftover goes.
                if (s_fetch_hw_i) l_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_aligner.sv
// Directed bench for instr_aligner: hand-computed vectors checked with
// immediate assertions, one linear stimulus sequence.
`timescale 1ns/1ps

module tb_instr_aligner;

    logic        clk;
    logic        resetn;
    logic        flush;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_data;
    logic [2:0]  fetch_error;
    logic        fetch_pred;
    logic        fetch_hw;
    logic        valid;
    logic        ready;
    logic [31:0] instr;
    logic [2:0]  out_error;
    logic        align_error;
    logic        prediction;

    int checks   = 0;
    int failures = 0;

    instr_aligner dut (
        .s_clk_i         (clk),
        .s_resetn_i      (resetn),
        .s_flush_i       (flush),
        .s_fetch_valid_i (fetch_valid),
        .s_fetch_ready_o (fetch_ready),
        .s_fetch_data_i  (fetch_data),
        .s_fetch_error_i (fetch_error),
        .s_fetch_pred_i  (fetch_pred),
        .s_fetch_hw_i    (fetch_hw),
        .s_valid_o       (valid),
        .s_ready_i       (ready),
        .s_instr_o       (instr),
        .s_fetch_error_o (out_error),
        .s_align_error_o (align_error),
        .s_prediction_o  (prediction)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1ns after the rising edge; outputs are sampled 5ns later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic offer(input logic [31:0] d, input logic [2:0] e,
                         input logic p, input logic h);
        fetch_valid = 1'b1;
        fetch_data  = d;
        fetch_error = e;
        fetch_pred  = p;
        fetch_hw    = h;
    endtask

    task automatic idle();
        fetch_valid = 1'b0;
        fetch_data  = 32'h0;
        fetch_error = 3'b000;
        fetch_pred  = 1'b0;
        fetch_hw    = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [31:0] i, input logic [2:0] e,
                              input logic a, input logic p);
        chk({tag, ".valid"}, {31'b0, valid}, 32'd1);
        chk({tag, ".instr"}, instr, i);
        chk({tag, ".err"}, {29'b0, out_error}, {29'b0, e});
        chk({tag, ".align"}, {31'b0, align_error}, {31'b0, a});
        chk({tag, ".pred"}, {31'b0, prediction}, {31'b0, p});
    endtask

    task automatic expect_none(input string tag);
        chk({tag, ".valid"}, {31'b0, valid}, 32'd0);
    endtask

    task automatic expect_fready(input string tag, input logic r);
        chk({tag, ".fetch_ready"}, {31'b0, fetch_ready}, {31'b0, r});
    endtask

    initial begin
        resetn = 1'b0;
        flush  = 1'b0;
        ready  = 1'b1;
        idle();
        next_cycle();
        next_cycle();
        settle();
        // Reset state
        expect_none("rst");
        chk("rst.instr", instr, 32'h0);
        chk("rst.err", {29'b0, out_error}, 32'd0);
        chk("rst.align", {31'b0, align_error}, 32'd0);
        chk("rst.pred", {31'b0, prediction}, 32'd0);
        expect_fready("rst", 1'b1);

        // T1 aligned RVI
        next_cycle(); resetn = 1'b1; offer(32'h00A50513, 3'b000, 1'b0, 1'b0);
        settle(); expect_none("t1.pre");
        next_cycle(); idle();
        settle(); expect_out("t1", 32'h00A50513, 3'b000, 1'b0, 1'b0);
        next_cycle();
        settle(); expect_none("t1.post");

        // T2 two RVC in one word
        offer(32'h45014505, 3'b000, 1'b0, 1'b0);
        next_cycle(); idle();
        settle(); expect_out("t2.a", 32'h00004505, 3'b000, 1'b0, 1'b0);
        expect_fready("t2.a", 1'b1);
        next_cycle();
        settle(); expect_out("t2.b", 32'h00004501, 3'b000, 1'b0, 1'b0);
        expect_fready("t2.b", 1'b1);
        next_cycle();
        settle(); expect_none("t2.post");

        // T3 split RVI across two words
        offer(32'h05134505, 3'b000, 1'b0, 1'b0);
        next_cycle(); offer(32'h450100A5, 3'b000, 1'b0, 1'b0);
        settle(); expect_out("t3.a", 32'h00004505, 3'b000, 1'b0, 1'b0);
        next_cycle(); idle();
        settle(); expect_out("t3.b", 32'h00A50513, 3'b000, 1'b0, 1'b0);
        next_cycle();
        settle(); expect_out("t3.c", 32'h00004501, 3'b000, 1'b0, 1'b0);
        next_cycle();
        settle(); expect_none("t3.post");

        // T4 predicted word whose upper half starts a 32-bit instruction
        offer(32'h05134505, 3'b000, 1'b1, 1'b0);
        next_cycle(); idle();
        settle(); expect_out("t4.a", 32'h00004505, 3'b000, 1'b0, 1'b0);
        next_cycle();
        settle(); expect_out("t4.b", 32'h00000513, 3'b000, 1'b1, 1'b1);
        next_cycle();
        settle(); expect_none("t4.post");
        expect_fready("t4.post", 1'b1);

        // Predicted word with RVC upper half: prediction rides on halfword1
        offer(32'h45014505, 3'b000, 1'b1, 1'b0);
        next_cycle(); idle();
        settle(); expect_out("p_rvc.a", 32'h00004505, 3'b000, 1'b0, 1'b0);
        next_cycle();
        settle(); expect_out("p_rvc.b", 32'h00004501, 3'b000, 1'b0, 1'b1);
        next_cycle();
        settle(); expect_none("p_rvc.post");

        // Halfword-aligned fetch target: halfword0 skipped
        offer(32'h4501ABCD, 3'b000, 1'b0, 1'b1);
        next_cycle(); idle();
        settle(); expect_out("hw", 32'h00004501, 3'b000, 1'b0, 1'b0);
        next_cycle();
        settle(); expect_none("hw.post");

        // T5 flush in the middle of a split instruction
        offer(32'h05134505, 3'b000, 1'b0, 1'b0);
        next_cycle(); idle();
        settle(); expect_out("t5.a", 32'h00004505, 3'b000, 1'b0, 1'b0);
        next_cycle(); flush = 1'b1; offer(32'h450100A5, 3'b000, 1'b0, 1'b0);
        settle(); expect_none("t5.flush");
        next_cycle(); flush = 1'b0; idle();
        settle(); expect_none("t5.after");
        offer(32'h00A50513, 3'b000, 1'b0, 1'b0);
        next_cycle(); idle();
        settle(); expect_out("t5.b", 32'h00A50513, 3'b000, 1'b0, 1'b0);
        next_cycle();
        settle(); expect_none("t5.post");

        // Reset in the middle of a split instruction
        offer(32'h05134505, 3'b000, 1'b0, 1'b0);
        next_cycle(); idle();
        settle(); expect_out("rs.a", 32'h00004505, 3'b000, 1'b0, 1'b0);
        next_cycle(); resetn = 1'b0;
        next_cycle(); resetn = 1'b1;
        settle(); expect_none("rs.after");
        expect_fready("rs.after", 1'b1);
        offer(32'h00A50513, 3'b000, 1'b0, 1'b0);
        next_cycle(); idle();
        settle(); expect_out("rs.b", 32'h00A50513, 3'b000, 1'b0, 1'b0);
        next_cycle();

        // T6 decoder stall, then a word carrying a fetch error
        ready = 1'b0;
        offer(32'h00A50513, 3'b000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            next_cycle(); offer(32'hDEADBEE3, 3'b010, 1'b0, 1'b0);
            settle(); expect_out("t6.stall", 32'h00A50513, 3'b000, 1'b0, 1'b0);
            expect_fready("t6.stall", 1'b0);
        end
        next_cycle(); ready = 1'b1;
        settle(); expect_out("t6.go", 32'h00A50513, 3'b000, 1'b0, 1'b0);
        expect_fready("t6.go", 1'b1);
        next_cycle(); idle();
        settle(); expect_out("t6.err", 32'hDEADBEE3, 3'b010, 1'b0, 1'b0);
        next_cycle();
        settle(); expect_none("t6.post");
        chk("t6.post.err", {29'b0, out_error}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
